// File: rtl/bp_lce_flow_ctrl_if.sv
// rtl/bp_lce_flow_ctrl_if.sv - cache request / LCE handshake bundle for the LCE flow-control unit
interface bp_lce_flow_ctrl_if #(
    parameter int credits_p = 8
);
    localparam int credit_width_lp = $clog2(credits_p + 1);

    logic                       cache_req_v_i;
    logic                       cache_req_v_o;
    logic                       req_ready_i;
    logic                       cmd_ready_i;
    logic                       lce_req_v_i;
    logic                       lce_req_yumi_i;
    logic                       cache_req_complete_i;
    logic                       uc_store_req_complete_i;
    logic                       data_mem_pkt_v_i;
    logic                       data_mem_pkt_yumi_i;
    logic                       tag_mem_pkt_v_i;
    logic                       tag_mem_pkt_yumi_i;
    logic                       stat_mem_pkt_v_i;
    logic                       stat_mem_pkt_yumi_i;
    logic [credit_width_lp-1:0] credit_count_o;
    logic                       credits_full_o;
    logic                       credits_empty_o;
    logic                       timeout_o;
    logic                       cache_req_busy_o;

    modport slave (
        input  cache_req_v_i, req_ready_i, cmd_ready_i,
        input  lce_req_v_i, lce_req_yumi_i,
        input  cache_req_complete_i, uc_store_req_complete_i,
        input  data_mem_pkt_v_i, data_mem_pkt_yumi_i,
        input  tag_mem_pkt_v_i, tag_mem_pkt_yumi_i,
        input  stat_mem_pkt_v_i, stat_mem_pkt_yumi_i,
        output cache_req_v_o, credit_count_o, credits_full_o, credits_empty_o,
        output timeout_o, cache_req_busy_o
    );

    modport master (
        output cache_req_v_i, req_ready_i, cmd_ready_i,
        output lce_req_v_i, lce_req_yumi_i,
        output cache_req_complete_i, uc_store_req_complete_i,
        output data_mem_pkt_v_i, data_mem_pkt_yumi_i,
        output tag_mem_pkt_v_i, tag_mem_pkt_yumi_i,
        output stat_mem_pkt_v_i, stat_mem_pkt_yumi_i,
        input  cache_req_v_o, credit_count_o, credits_full_o, credits_empty_o,
        input  timeout_o, cache_req_busy_o
    );
endinterface

// File: rtl/bp_lce_flow_ctrl.sv
// rtl/bp_lce_flow_ctrl.sv - LCE credit/timeout back-pressure and cache request valid gating
module bp_lce_flow_ctrl #(
    parameter int credits_p           = 8,
    parameter int timeout_max_limit_p = 4
) (
    input logic               clk_i,
    input logic               reset_i,
    bp_lce_flow_ctrl_if.slave lce
);
    localparam int credit_width_lp  = $clog2(credits_p + 1);
    localparam int timeout_width_lp = $clog2(timeout_max_limit_p + 1);
    localparam int sum_width_lp     = credit_width_lp + 2;

    localparam logic [credit_width_lp-1:0]         credits_max_lp   = credit_width_lp'(credits_p);
    localparam logic [timeout_width_lp-1:0]        timeout_max_lp   = timeout_width_lp'(timeout_max_limit_p);
    localparam logic signed [sum_width_lp-1:0]     credits_limit_lp = sum_width_lp'(credits_p);

    logic [credit_width_lp-1:0]     credit_count_r;
    logic [credit_width_lp-1:0]     credit_count_n;
    logic [timeout_width_lp-1:0]    timeout_count_r;
    logic [timeout_width_lp-1:0]    timeout_count_n;
    logic                           blocked;
    logic                           credit_consume;
    logic signed [sum_width_lp-1:0] credit_sum;
    logic                           credit_overflow;
    logic                           credit_underflow;
    logic                           busy;

    always_comb begin
        blocked = (lce.data_mem_pkt_v_i & ~lce.data_mem_pkt_yumi_i)
                | (lce.tag_mem_pkt_v_i  & ~lce.tag_mem_pkt_yumi_i)
                | (lce.stat_mem_pkt_v_i & ~lce.stat_mem_pkt_yumi_i);
        credit_consume = lce.lce_req_v_i & lce.lce_req_yumi_i;
    end

    // Net credit change is evaluated in a wider signed domain so both clamps are visible.
    always_comb begin
        credit_sum = $signed({2'b00, credit_count_r})
                   + $signed(sum_width_lp'(credit_consume))
                   - $signed(sum_width_lp'(lce.cache_req_complete_i))
                   - $signed(sum_width_lp'(lce.uc_store_req_complete_i));
        credit_overflow  = (credit_sum > credits_limit_lp);
        credit_underflow = credit_sum[sum_width_lp-1];
        if (credit_overflow) begin
            credit_count_n = credits_max_lp;
        end else if (credit_underflow) begin
            credit_count_n = '0;
        end else begin
            credit_count_n = credit_sum[credit_width_lp-1:0];
        end
    end

    always_comb begin
        timeout_count_n = '0;
        if (blocked) begin
            timeout_count_n = (timeout_count_r == timeout_max_lp)
                            ? timeout_max_lp
                            : timeout_count_r + timeout_width_lp'(1);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            credit_count_r  <= '0;
            timeout_count_r <= '0;
        end else begin
            credit_count_r  <= credit_count_n;
            timeout_count_r <= timeout_count_n;
        end
    end

    always_comb begin
        busy = (credit_count_r == credits_max_lp)
             | (timeout_count_r == timeout_max_lp)
             | ~lce.cmd_ready_i
             | ~lce.req_ready_i;
    end

    assign lce.credit_count_o   = credit_count_r;
    assign lce.credits_full_o   = (credit_count_r == credits_max_lp);
    assign lce.credits_empty_o  = (credit_count_r == '0);
    assign lce.timeout_o        = (timeout_count_r == timeout_max_lp);
    assign lce.cache_req_busy_o = busy;
    assign lce.cache_req_v_o    = lce.cache_req_v_i & ~busy;

`ifndef SYNTHESIS
    always @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!credit_overflow) else $error("bp_lce_flow_ctrl: credit counter overflow");
            assert (!credit_underflow) else $error("bp_lce_flow_ctrl: credit counter underflow");
        end
    end
`endif
endmodule

// File: tb/tb_bp_lce_flow_ctrl.sv
// tb/tb_bp_lce_flow_ctrl.sv - directed and randomized checks of bp_lce_flow_ctrl against a behavioural model
module tb_bp_lce_flow_ctrl;
    localparam int credits_lp = 8;
    localparam int timeout_lp = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bp_lce_flow_ctrl_if #(.credits_p(credits_lp)) lce_if ();

    bp_lce_flow_ctrl #(
        .credits_p          (credits_lp),
        .timeout_max_limit_p(timeout_lp)
    ) dut (
        .clk_i  (clk),
        .reset_i(reset),
        .lce    (lce_if)
    );

    int checks = 0;
    int errors = 0;
    // Model: outstanding credits and length of the current run of blocked cycles.
    int m_credits = 0;
    int m_run     = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit stim_blocked();
        return (lce_if.data_mem_pkt_v_i && !lce_if.data_mem_pkt_yumi_i)
            || (lce_if.tag_mem_pkt_v_i  && !lce_if.tag_mem_pkt_yumi_i)
            || (lce_if.stat_mem_pkt_v_i && !lce_if.stat_mem_pkt_yumi_i);
    endfunction

    task automatic clear_inputs();
        lce_if.cache_req_v_i           = 1'b0;
        lce_if.req_ready_i             = 1'b1;
        lce_if.cmd_ready_i             = 1'b1;
        lce_if.lce_req_v_i             = 1'b0;
        lce_if.lce_req_yumi_i          = 1'b0;
        lce_if.cache_req_complete_i    = 1'b0;
        lce_if.uc_store_req_complete_i = 1'b0;
        lce_if.data_mem_pkt_v_i        = 1'b0;
        lce_if.data_mem_pkt_yumi_i     = 1'b0;
        lce_if.tag_mem_pkt_v_i         = 1'b0;
        lce_if.tag_mem_pkt_yumi_i      = 1'b0;
        lce_if.stat_mem_pkt_v_i        = 1'b0;
        lce_if.stat_mem_pkt_yumi_i     = 1'b0;
    endtask

    // Called 1 time unit after a rising edge with inputs already applied.
    task automatic cycle();
        bit exp_timeout;
        bit exp_busy;
        #2;
        exp_timeout = (m_run >= timeout_lp);
        exp_busy    = (m_credits == credits_lp) || exp_timeout
                   || !lce_if.cmd_ready_i || !lce_if.req_ready_i;
        check("credit_count", lce_if.credit_count_o, m_credits);
        check("credits_full", lce_if.credits_full_o, m_credits == credits_lp);
        check("credits_empty", lce_if.credits_empty_o, m_credits == 0);
        check("timeout", lce_if.timeout_o, exp_timeout);
        check("busy", lce_if.cache_req_busy_o, exp_busy);
        check("cache_req_v_o", lce_if.cache_req_v_o, lce_if.cache_req_v_i && !exp_busy);
        @(posedge clk);
        m_run = stim_blocked() ? m_run + 1 : 0;
        m_credits = m_credits + int'(lce_if.lce_req_v_i && lce_if.lce_req_yumi_i)
                  - int'(lce_if.cache_req_complete_i) - int'(lce_if.uc_store_req_complete_i);
        #1;
    endtask

    initial begin
        clear_inputs();
        lce_if.cmd_ready_i = 1'b0;
        reset = 1'b1;
        #1;
        check("rst_count", lce_if.credit_count_o, 0);
        check("rst_empty", lce_if.credits_empty_o, 1);
        check("rst_full", lce_if.credits_full_o, 0);
        check("rst_timeout", lce_if.timeout_o, 0);
        check("rst_busy_cmd", lce_if.cache_req_busy_o, 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_credits = 0;
        m_run = 0;

        // Idle, ready: request passes straight through.
        lce_if.cmd_ready_i   = 1'b1;
        lce_if.cache_req_v_i = 1'b1;
        #1;
        check("idle_busy", lce_if.cache_req_busy_o, 0);
        check("idle_v_o", lce_if.cache_req_v_o, 1);
        cycle();

        // Fill all credits.
        for (int i = 0; i < credits_lp; i++) begin
            lce_if.lce_req_v_i    = 1'b1;
            lce_if.lce_req_yumi_i = 1'b1;
            cycle();
            check("fill_count", lce_if.credit_count_o, i + 1);
        end
        lce_if.lce_req_v_i    = 1'b0;
        lce_if.lce_req_yumi_i = 1'b0;
        #1;
        check("full_flag", lce_if.credits_full_o, 1);
        check("full_busy", lce_if.cache_req_busy_o, 1);
        check("full_v_o", lce_if.cache_req_v_o, 0);
        cycle();
        lce_if.cache_req_complete_i = 1'b1;
        cycle();
        lce_if.cache_req_complete_i = 1'b0;
        #1;
        check("return_count", lce_if.credit_count_o, 7);
        check("return_busy", lce_if.cache_req_busy_o, 0);
        check("return_v_o", lce_if.cache_req_v_o, 1);
        cycle();

        // Timeout: blocked data-mem packet.
        lce_if.cache_req_v_i    = 1'b0;
        lce_if.data_mem_pkt_v_i = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            #1;
            check($sformatf("timeout_cyc%0d", k), lce_if.timeout_o, k >= 4);
            cycle();
        end
        lce_if.data_mem_pkt_yumi_i = 1'b1;
        #1;
        check("timeout_cyc11", lce_if.timeout_o, 1);
        cycle();
        lce_if.data_mem_pkt_v_i    = 1'b0;
        lce_if.data_mem_pkt_yumi_i = 1'b0;
        #1;
        check("timeout_cyc12", lce_if.timeout_o, 0);
        cycle();

        // Net-sum credit updates from count 3.
        lce_if.cache_req_complete_i = 1'b1;
        repeat (4) cycle();
        check("net_start", lce_if.credit_count_o, 3);
        lce_if.lce_req_v_i             = 1'b1;
        lce_if.lce_req_yumi_i          = 1'b1;
        lce_if.uc_store_req_complete_i = 1'b1;
        cycle();
        check("net_minus1", lce_if.credit_count_o, 2);
        lce_if.uc_store_req_complete_i = 1'b0;
        cycle();
        check("net_zero", lce_if.credit_count_o, 2);
        lce_if.lce_req_v_i             = 1'b0;
        lce_if.lce_req_yumi_i          = 1'b0;
        lce_if.uc_store_req_complete_i = 1'b1;
        cycle();
        check("double_return", lce_if.credit_count_o, 0);
        clear_inputs();

        // Not-ready engines force busy.
        lce_if.cache_req_v_i = 1'b1;
        lce_if.cmd_ready_i   = 1'b0;
        #1;
        check("cmd_busy", lce_if.cache_req_busy_o, 1);
        check("cmd_v_o", lce_if.cache_req_v_o, 0);
        cycle();
        lce_if.cmd_ready_i = 1'b1;
        lce_if.req_ready_i = 1'b0;
        #1;
        check("req_busy", lce_if.cache_req_busy_o, 1);
        check("req_v_o", lce_if.cache_req_v_o, 0);
        cycle();
        clear_inputs();

        // Asynchronous reset with count 5 and timeout count 3.
        lce_if.lce_req_v_i    = 1'b1;
        lce_if.lce_req_yumi_i = 1'b1;
        repeat (5) cycle();
        lce_if.lce_req_v_i      = 1'b0;
        lce_if.lce_req_yumi_i   = 1'b0;
        lce_if.data_mem_pkt_v_i = 1'b1;
        repeat (3) cycle();
        check("pre_rst_count", lce_if.credit_count_o, 5);
        check("pre_rst_tcount", dut.timeout_count_r, 3);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_count", lce_if.credit_count_o, 0);
        check("async_rst_empty", lce_if.credits_empty_o, 1);
        check("async_rst_tcount", dut.timeout_count_r, 0);
        m_credits = 0;
        m_run = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        // Still blocked: timeout must need a full run again.
        for (int k = 0; k < 6; k++) cycle();
        clear_inputs();
        cycle();

        // Randomized traffic.
        for (int n = 0; n < 500; n++) begin
            bit ca, ub, v, y;
            ca = ($urandom % 4 == 0) && (m_credits >= 1);
            ub = ($urandom % 5 == 0) && (m_credits >= 1 + int'(ca));
            v  = ($urandom % 4 != 0);
            y  = ($urandom % 3 != 0);
            if (v && y && (m_credits - int'(ca) - int'(ub) + 1 > credits_lp)) y = 1'b0;
            lce_if.cache_req_complete_i    = ca;
            lce_if.uc_store_req_complete_i = ub;
            lce_if.lce_req_v_i             = v;
            lce_if.lce_req_yumi_i          = y;
            lce_if.cache_req_v_i           = ($urandom % 2 == 0);
            lce_if.cmd_ready_i             = ($urandom % 8 != 0);
            lce_if.req_ready_i             = ($urandom % 8 != 0);
            lce_if.data_mem_pkt_v_i        = ($urandom % 3 == 0);
            lce_if.data_mem_pkt_yumi_i     = ($urandom % 3 == 0);
            lce_if.tag_mem_pkt_v_i         = ($urandom % 3 == 0);
            lce_if.tag_mem_pkt_yumi_i      = ($urandom % 3 == 0);
            lce_if.stat_mem_pkt_v_i        = ($urandom % 3 == 0);
            lce_if.stat_mem_pkt_yumi_i     = ($urandom % 3 == 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
